// File: rtl/serializador_pkg.sv
// Shared types and helpers for the serial word link transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serializador_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2,
        GAP   = 2'd3
    } state_ser_t;

    localparam int DEFAULT_WORD_WIDTH = 8;

    // Even parity over a word, zero-extended to 64 bits by the caller.
    function automatic logic even_parity(input logic [63:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/serializador_if.sv
// Word-side handshake and serial-side strobe bundle of the transmitter.
// Latency: n/a (wires only).
// Backpressure: status_in from the receiver throttles the serial side.
interface serializador_if
    import serializador_pkg::*;
#(
    parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH
);

    logic [WORD_WIDTH-1:0] data_in;
    logic                  data_valid_in;
    logic                  ack_out;
    logic                  status_in;
    logic                  serial_out;
    logic                  write_out;
    logic                  busy_out;

    // Environment side: queue plus receiver status.
    modport master (
        output data_in, data_valid_in, status_in,
        input  ack_out, serial_out, write_out, busy_out
    );

    // Transmitter side.
    modport slave (
        input  data_in, data_valid_in, status_in,
        output ack_out, serial_out, write_out, busy_out
    );

endinterface

// File: rtl/serializador_shreg.sv
// Loadable right-shift register with hold, LSB serial tap and bit counter with last flag.
// Latency: load/shift take effect on the next clock edge.
// Backpressure: shift_en low holds contents and count unchanged.
module serializador_shreg
    import serializador_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WORD_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock_100KHz,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_dat,
    input  logic             shift_en,
    output logic             lsb,
    output logic             last
);

    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] bit_cnt;

    // Load a new frame or shift one bit out; the counter saturates at WIDTH.
    always_ff @(posedge clock_100KHz or posedge reset) begin
        if (reset) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            shreg   <= load_dat;
            bit_cnt <= '0;
        end else if (shift_en) begin
            shreg <= shreg >> 1;
            if (bit_cnt != CNT_W'(WIDTH)) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    assign lsb  = shreg[0];
    assign last = (bit_cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/serializador.sv
// Serial word transmitter: pops a word, shifts it out LSB first with write_out strobe, then idles GAP_CYCLES.
// Latency: ack_out the cycle after data_valid_in&&status_in in IDLE; first bit the cycle after ack_out.
// Backpressure: status_in=0 holds the current bit (HOLD); optional parity bit via SERIALIZADOR_PARITY_EN.
module serializador
    import serializador_pkg::*;
#(
    parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
    parameter int GAP_CYCLES = 1
) (
    input  logic          clock_100KHz,
    input  logic          reset,
    serializador_if.slave bus
);

`ifdef SERIALIZADOR_PARITY_EN
    localparam int FRAME_LEN = WORD_WIDTH + 1;
`else
    localparam int FRAME_LEN = WORD_WIDTH;
`endif

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_SHIFT = SHIFT;
    localparam logic [1:0] ST_HOLD  = HOLD;
    localparam logic [1:0] ST_GAP   = GAP;
    localparam logic [4:0] GAP_LEN  = 5'(GAP_CYCLES);

    logic [1:0]           state;
    logic [3:0]           gap_cnt;
    logic                 ack_q;
    logic                 serial_q;
    logic                 write_q;
    logic                 load;
    logic                 shift_en;
    logic                 lsb;
    logic                 last;
    logic [FRAME_LEN-1:0] load_dat;

    // A word is captured only from IDLE, and only while the receiver can accept.
    assign load     = (state == ST_IDLE) && bus.data_valid_in && bus.status_in;
    assign shift_en = ((state == ST_SHIFT) || (state == ST_HOLD)) && bus.status_in;

`ifdef SERIALIZADOR_PARITY_EN
    assign load_dat = {even_parity(64'(bus.data_in)), bus.data_in};
`else
    assign load_dat = bus.data_in;
`endif

    serializador_shreg #(
        .WIDTH (FRAME_LEN)
    ) u_shreg (
        .clock_100KHz (clock_100KHz),
        .reset        (reset),
        .load         (load),
        .load_dat     (load_dat),
        .shift_en     (shift_en),
        .lsb          (lsb),
        .last         (last)
    );

    // Frame sequencing with registered outputs; SHIFT and HOLD both resume on status_in.
    always_ff @(posedge clock_100KHz or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            gap_cnt  <= '0;
            ack_q    <= 1'b0;
            serial_q <= 1'b0;
            write_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    gap_cnt  <= '0;
                    serial_q <= 1'b0;
                    write_q  <= 1'b0;
                    ack_q    <= load;
                    if (load) begin
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT, ST_HOLD: begin
                    ack_q   <= 1'b0;
                    gap_cnt <= '0;
                    if (bus.status_in) begin
                        serial_q <= lsb;
                        write_q  <= 1'b1;
                        if (last) begin
                            state <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                        end else begin
                            state <= ST_SHIFT;
                        end
                    end else begin
                        // serial_q keeps the last sent bit while stalled.
                        write_q <= 1'b0;
                        state   <= ST_HOLD;
                    end
                end
                ST_GAP: begin
                    ack_q    <= 1'b0;
                    serial_q <= 1'b0;
                    write_q  <= 1'b0;
                    if (({1'b0, gap_cnt} + 5'd1) >= GAP_LEN) begin
                        gap_cnt <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                default: begin
                    ack_q    <= 1'b0;
                    serial_q <= 1'b0;
                    write_q  <= 1'b0;
                    gap_cnt  <= '0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ack_out    = ack_q;
    assign bus.serial_out = serial_q;
    assign bus.write_out  = write_q;
    assign bus.busy_out   = (state != ST_IDLE);

endmodule

// File: tb/tb_serializador.sv
// Directed bench for serializador: queue model on the word side, bit scoreboard on the serial side.
// Latency: checks ack/first-bit timing, HOLD stalls, gap spacing and async reset.
// Backpressure: status_in is driven low to exercise HOLD and receiver-busy.
`timescale 1ns/1ps
module tb_serializador;

`ifdef SERIALIZADOR_PARITY_EN
    localparam int FRAME_BITS = 9;
`else
    localparam int FRAME_BITS = 8;
`endif

    logic clk = 1'b0;
    logic reset;

    serializador_if #(.WORD_WIDTH(8)) bus ();

    serializador #(
        .WORD_WIDTH (8),
        .GAP_CYCLES (1)
    ) dut (
        .clock_100KHz (clk),
        .reset        (reset),
        .bus          (bus)
    );

    // Upstream queue: stimulus writes wr_ptr, monitor pops on ack_out.
    logic [7:0] tx_mem [0:15];
    logic [3:0] wr_ptr = '0;
    logic [3:0] rd_ptr = '0;
    assign bus.data_valid_in = (wr_ptr != rd_ptr);
    assign bus.data_in       = tx_mem[rd_ptr];

    // Expected serial bits in transmit order.
    logic exp_bits [0:511];
    int   exp_wr     = 0;
    int   exp_rd     = 0;
    int   flush_mark = 0;

    int ack_cyc [0:31];
    int n_ack  = 0;
    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    initial begin
        forever #5000 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // frame holds the hand-computed serial order MSB-first: 8 data bits then parity bit.
    task automatic push_word(input logic [7:0] w, input logic [8:0] frame);
        tx_mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 4'd1;
        for (int i = 8; i > 8 - FRAME_BITS; i--) begin
            exp_bits[exp_wr] = frame[i];
            exp_wr++;
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ack();
        int n = 0;
        do begin
            step(1);
            n++;
        end while (!bus.ack_out && n < 40);
        if (!bus.ack_out) begin
            errors++;
            $display("FAIL ack_timeout actual=no ack expected=ack within 40 cycles");
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((bus.busy_out || bus.write_out || wr_ptr != rd_ptr) && n < 200) begin
            step(1);
            n++;
        end
        if (n >= 200) begin
            errors++;
            $display("FAIL idle_timeout actual=busy expected=idle within 200 cycles");
        end
        step(2);
    endtask

    // Monitor: pops the scoreboard on every strobed bit, records ack pulses.
    initial begin
        logic ack_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_rd   = flush_mark;
                ack_prev = 1'b0;
            end else begin
                if (bus.ack_out) begin
                    check("ack_single_pulse", int'(ack_prev), 0);
                    ack_cyc[n_ack] = cyc;
                    n_ack++;
                    rd_ptr = rd_ptr + 4'd1;
                end
                ack_prev = bus.ack_out;
                if (bus.write_out) begin
                    checks++;
                    if (exp_rd == exp_wr) begin
                        errors++;
                        $display("FAIL extra_bit actual=strobe serial_out=%0d expected=no strobe (cycle %0d)",
                                 bus.serial_out, cyc);
                    end else begin
                        if (bus.serial_out != exp_bits[exp_rd]) begin
                            errors++;
                            $display("FAIL serial_bit idx=%0d actual=%0d expected=%0d (cycle %0d)",
                                     exp_rd, bus.serial_out, exp_bits[exp_rd], cyc);
                        end
                        exp_rd++;
                    end
                end
            end
        end
    end

    initial begin
        int n0;
        reset         = 1'b1;
        bus.status_in = 1'b0;
        #1;
        check("rst_ack", int'(bus.ack_out), 0);
        check("rst_serial", int'(bus.serial_out), 0);
        check("rst_write", int'(bus.write_out), 0);
        check("rst_busy", int'(bus.busy_out), 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        step(2);

        // Single word 0x41 -> 1,0,0,0,0,0,1,0 ; parity 0
        bus.status_in = 1'b1;
        push_word(8'h41, 9'b10000010_0);
        wait_ack();
        check("single_busy_on_ack", int'(bus.busy_out), 1);
        step(FRAME_BITS);
        check("single_last_write", int'(bus.write_out), 1);
        check("single_gap_busy", int'(bus.busy_out), 1);
        step(1);
        check("single_gap_write", int'(bus.write_out), 0);
        check("single_gap_serial", int'(bus.serial_out), 0);
        check("single_idle_busy", int'(bus.busy_out), 0);
        wait_idle();

        // Throttle 0xC3 -> 1,1,0,0,0,0,1,1 ; stall after bit index 2
        push_word(8'hC3, 9'b11000011_0);
        wait_ack();
        step(3);
        check("thr_bit2_write", int'(bus.write_out), 1);
        bus.status_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("thr_hold_write", int'(bus.write_out), 0);
            check("thr_hold_serial", int'(bus.serial_out), 0);
        end
        bus.status_in = 1'b1;
        step(1);
        check("thr_resume_write", int'(bus.write_out), 1);
        check("thr_resume_bit3", int'(bus.serial_out), 0);
        wait_idle();

        // Back-to-back 0x01, 0xFF
        n0 = n_ack;
        push_word(8'h01, 9'b10000000_1);
        push_word(8'hFF, 9'b11111111_0);
        wait_idle();
        check("b2b_ack_count", n_ack - n0, 2);
        check("b2b_ack_spacing", ack_cyc[n0 + 1] - ack_cyc[n0], FRAME_BITS + 2);

        // Receiver busy for 10 cycles with a word waiting
        bus.status_in = 1'b0;
        push_word(8'h5A, 9'b01011010_0);
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("busy_no_ack", int'(bus.ack_out), 0);
            check("busy_no_write", int'(bus.write_out), 0);
        end
        bus.status_in = 1'b1;
        step(1);
        check("busy_ack_after_status", int'(bus.ack_out), 1);
        wait_idle();

        // Reset after 3 bits of 0xA5 -> 1,0,1,...
        push_word(8'hA5, 9'b10100101_0);
        wait_ack();
        step(3);
        check("rstmid_third_bit_write", int'(bus.write_out), 1);
        check("rstmid_third_bit_value", int'(bus.serial_out), 1);
        flush_mark = exp_wr;
        reset = 1'b1;
        #1;
        check("rstmid_ack", int'(bus.ack_out), 0);
        check("rstmid_serial", int'(bus.serial_out), 0);
        check("rstmid_write", int'(bus.write_out), 0);
        check("rstmid_busy", int'(bus.busy_out), 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        n0 = n_ack;
        step(15);
        check("rstmid_no_repop", n_ack - n0, 0);
        check("rstmid_queue_empty", int'(wr_ptr - rd_ptr), 0);

        // 0x07 -> 1,1,1,0,0,0,0,0 parity 1 ; 0x03 -> 1,1,0,0,0,0,0,0 parity 0
        push_word(8'h07, 9'b11100000_1);
        push_word(8'h03, 9'b11000000_0);
        wait_idle();

        step(2);
        check("all_bits_seen", exp_rd, exp_wr);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
